// File: rtl/row_fifo_read_seq_if.sv
// Bundles the request and read-enable signals of the row FIFO read sequencer.
// No logic and no latency: it only carries signals between the two sides.
// The master drives the request inputs; the slave drives o_read_enable, o_busy and o_done.
// Building with ROW_FIFO_EMPTY_GUARD_EN defined adds the per-row i_empty input.
interface row_fifo_read_seq_if #(
    parameter int ROW   = 9,
    parameter int LEN_W = 8,
    parameter int SEL_W = $clog2(ROW + 1)
);
    logic             i_start;
    logic             i_mode;
    logic [SEL_W-1:0] i_sel;
    logic [LEN_W-1:0] i_len;
    logic             i_stall;
`ifdef ROW_FIFO_EMPTY_GUARD_EN
    logic [ROW-1:0]   i_empty;
`endif
    logic [ROW-1:0]   o_read_enable;
    logic             o_busy;
    logic             o_done;

    // Burst requester side.
    modport master (
        output i_start,
        output i_mode,
        output i_sel,
        output i_len,
        output i_stall,
`ifdef ROW_FIFO_EMPTY_GUARD_EN
        output i_empty,
`endif
        input  o_read_enable,
        input  o_busy,
        input  o_done
    );

    // Sequencer side.
    modport slave (
        input  i_start,
        input  i_mode,
        input  i_sel,
        input  i_len,
        input  i_stall,
`ifdef ROW_FIFO_EMPTY_GUARD_EN
        input  i_empty,
`endif
        output o_read_enable,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/row_fifo_read_seq.sv
// Counted read-enable burst engine for ROW row FIFOs: single-row burst or diagonal all-row wavefront.
// Latency: the first enable appears one cycle after start; o_done pulses one cycle after the last enable.
// Backpressure: i_stall (and i_empty under ROW_FIFO_EMPTY_GUARD_EN) freezes the counter and zeroes all enables.
module row_fifo_read_seq #(
    parameter int ROW   = 9,
    parameter int LEN_W = 8,
    parameter int SEL_W = $clog2(ROW + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    row_fifo_read_seq_if.slave bus
);
    // The counter has to reach len+ROW-2 in skew mode; this width always holds that value.
    localparam int CW = LEN_W + SEL_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CW-1:0]    t_q, t_d;

    logic [ROW-1:0]   en_raw;
    logic [ROW-1:0]   rd_en;
    logic [CW-1:0]    t_last;
    logic             stall_eff;
    logic             start_empty;

    // Enable pattern for the current count, decoded only from registered mode/sel/len/t.
    always_comb begin
        en_raw = '0;
        for (int r = 0; r < ROW; r++) begin
            if (mode_q) begin
                // Row r lags row 0 by r cycles and stays on for len cycles.
                en_raw[r] = (t_q >= CW'(r)) && (t_q < (CW'(r) + CW'(len_q)));
            end else begin
                // sel is 1-based, so row r matches sel == r+1.
                en_raw[r] = (CW'(sel_q) == CW'(r + 1));
            end
        end
    end

    // Final count value of the burst; len is nonzero whenever RUN is entered.
    always_comb begin
        t_last = '0;
        if (mode_q) begin
            t_last = CW'(len_q) + CW'(ROW - 1) - CW'(1);
        end else begin
            t_last = CW'(len_q) - CW'(1);
        end
    end

    // A cycle is held when paused externally, or when a row about to be read is empty.
    always_comb begin
`ifdef ROW_FIFO_EMPTY_GUARD_EN
        stall_eff = bus.i_stall | (|(en_raw & bus.i_empty));
`else
        stall_eff = bus.i_stall;
`endif
    end

    // Requests with nothing to read skip RUN and complete straight away.
    always_comb begin
        start_empty = (bus.i_len == '0) ||
                      (!bus.i_mode && ((bus.i_sel == '0) || (bus.i_sel > SEL_W'(ROW))));
    end

    // Next-state and capture logic.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        len_d   = len_q;
        t_d     = t_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    mode_d  = bus.i_mode;
                    sel_d   = bus.i_sel;
                    len_d   = bus.i_len;
                    t_d     = '0;
                    state_d = start_empty ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (!stall_eff) begin
                    if (t_q == t_last) begin
                        state_d = S_DONE;
                    end else begin
                        t_d = t_q + CW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, captured request and counter registers; reset aborts any burst silently.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            sel_q   <= '0;
            len_q   <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            t_q     <= t_d;
        end
    end

    // Enables are live only in RUN and are dropped for the whole array on any hold.
    always_comb begin
        rd_en = '0;
        if ((state_q == S_RUN) && !stall_eff) begin
            rd_en = en_raw;
        end
    end

    assign bus.o_read_enable = rd_en;
    assign bus.o_busy        = (state_q == S_RUN);
    assign bus.o_done        = (state_q == S_DONE);

endmodule
